// File: rtl/alu_op_encoder.sv
// Inverse of the opcode-to-select decoder: turns 12-bit one-hot ALU selects into 4-bit opcodes,
// queued in a small FIFO. Define ALU_OP_ENC_PRIORITY_EN to encode multi-hot words by lowest set bit.
module alu_op_encoder #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sel_valid,
  input  logic [11:0]              sel,
  output logic                     sel_ready,
  output logic                     op_valid,
  output logic [3:0]               op,
  input  logic                     op_ready,
  output logic                     err,
  output logic [ERRW-1:0]          err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    last_op;
  logic [3:0]    enc_op;
  logic [3:0]    hot_cnt;
  logic          well_formed;
  logic          in_xfer;
  logic          push;
  logic          pop;

  function automatic logic [3:0] bit_to_op(input int idx);
    logic [3:0] code;
    case (idx)
      0:       code = 4'b0000;
      1:       code = 4'b0001;
      2:       code = 4'b0010;
      3:       code = 4'b0011;
      4:       code = 4'b0100;
      5:       code = 4'b0101;
      6:       code = 4'b0110;
      7:       code = 4'b1000;
      8:       code = 4'b1001;
      9:       code = 4'b1010;
      10:      code = 4'b1011;
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

  // Scanning from the top down leaves the lowest set bit's opcode in enc_op.
  always_comb begin
    enc_op  = 4'b0000;
    hot_cnt = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (sel[i]) begin
        enc_op  = bit_to_op(i);
        hot_cnt = hot_cnt + 4'd1;
      end
    end
`ifdef ALU_OP_ENC_PRIORITY_EN
    well_formed = (hot_cnt != 4'd0);
`else
    well_formed = (hot_cnt == 4'd1);
`endif
  end

  assign sel_ready = (level != LW'(DEPTH));
  assign op_valid  = (level != '0);
  assign in_xfer   = sel_valid && sel_ready;
  assign push      = in_xfer && well_formed;
  assign pop       = op_valid && op_ready;
  assign op        = op_valid ? mem[rd_ptr] : last_op;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_op   <= 4'b0000;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        last_op <= mem[rd_ptr];
      end
      level <= level + LW'(push) - LW'(pop);
      err   <= in_xfer && !well_formed;
      // Rejected words still complete the handshake; the counter sticks at all-ones.
      if (in_xfer && !well_formed && (err_count != '1)) begin
        err_count <= err_count + ERRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Scoreboard bench for alu_op_encoder: random and directed select words against a queue-based model.
// Honours ALU_OP_ENC_PRIORITY_EN when the build defines it.
module tb_alu_op_encoder;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
  localparam int ERRMAX = (1 << ERRW) - 1;
  localparam logic [3:0] OPTAB [0:11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                          4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};

  logic                   clk;
  logic                   reset_n;
  logic                   sel_valid;
  logic [11:0]            sel;
  logic                   sel_ready;
  logic                   op_valid;
  logic [3:0]             op;
  logic                   op_ready;
  logic                   err;
  logic [ERRW-1:0]        err_count;
  logic [$clog2(DEPTH):0] level;

  int vectors;
  int miscompares;

  logic [3:0] exp_q [$];
  logic [3:0] last_pop;
  logic       exp_err;
  int         exp_cnt;

  alu_op_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk(clk), .reset_n(reset_n), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(sel_ready), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .err(err), .err_count(err_count), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_ok(input logic [11:0] s);
`ifdef ALU_OP_ENC_PRIORITY_EN
    return s != 12'h000;
`else
    return $countones(s) == 1;
`endif
  endfunction

  function automatic logic [3:0] model_op(input logic [11:0] s);
    for (int i = 0; i < 12; i++) begin
      if (s[i]) return OPTAB[i];
    end
    return 4'h0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [11:0] s, input logic rdy);
    @(posedge clk);
    #1;
    sel_valid = v;
    sel       = s;
    op_ready  = rdy;
  endtask

  // Monitor: at the falling edge, check state against the model, then advance the model
  // by the transfers the next rising edge will perform.
  initial begin
    logic do_pop;
    logic do_push;
    exp_q.delete();
    last_pop = 4'h0;
    exp_err  = 1'b0;
    exp_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        last_pop = 4'h0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
      end else begin
        check_output("level", 32'(level), 32'(exp_q.size()));
        check_output("op_valid", 32'(op_valid), 32'(exp_q.size() != 0));
        check_output("sel_ready", 32'(sel_ready), 32'(exp_q.size() != DEPTH));
        check_output("op", 32'(op), 32'((exp_q.size() != 0) ? exp_q[0] : last_pop));
        check_output("err", 32'(err), 32'(exp_err));
        check_output("err_count", 32'(err_count), 32'(exp_cnt));
        do_pop  = (exp_q.size() != 0) && op_ready;
        do_push = sel_valid && (exp_q.size() != DEPTH);
        if (do_pop) last_pop = exp_q.pop_front();
        exp_err = do_push && !model_ok(sel);
        if (exp_err && exp_cnt < ERRMAX) exp_cnt++;
        if (do_push && model_ok(sel)) exp_q.push_back(model_op(sel));
      end
    end
  end

  initial begin
    logic [11:0] s;
    int r;
    vectors     = 0;
    miscompares = 0;
    reset_n   = 1'b0;
    sel_valid = 1'b0;
    sel       = 12'h000;
    op_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_op_valid", 32'(op_valid), 32'd0);
    check_output("reset_sel_ready", 32'(sel_ready), 32'd1);
    check_output("reset_op", 32'(op), 32'd0);
    reset_n = 1'b1;

    // Single push, head visible one edge later
    apply_stimulus(1'b1, 12'h080, 1'b0);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("first_op", 32'(op), 32'h8);
    check_output("first_level", 32'(level), 32'd1);
    apply_stimulus(1'b0, 12'h000, 1'b1);
    apply_stimulus(1'b0, 12'h000, 1'b0);

    // Fill to DEPTH, then a simultaneous push attempt and pop while full
    apply_stimulus(1'b1, 12'h001, 1'b0);
    apply_stimulus(1'b1, 12'h002, 1'b0);
    apply_stimulus(1'b1, 12'h400, 1'b0);
    apply_stimulus(1'b1, 12'h800, 1'b0);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("full_sel_ready", 32'(sel_ready), 32'd0);
    check_output("full_level", 32'(level), 32'd4);
    apply_stimulus(1'b1, 12'h010, 1'b1);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("after_full_pop_level", 32'(level), 32'd3);
    check_output("after_full_pop_ready", 32'(sel_ready), 32'd1);
    repeat (4) apply_stimulus(1'b0, 12'h000, 1'b1);

    // Malformed words
    apply_stimulus(1'b1, 12'h000, 1'b0);
    apply_stimulus(1'b1, 12'h003, 1'b0);
    apply_stimulus(1'b0, 12'h000, 1'b0);
`ifdef ALU_OP_ENC_PRIORITY_EN
    check_output("malformed_count", 32'(err_count), 32'd1);
    check_output("malformed_level", 32'(level), 32'd1);
`else
    check_output("malformed_count", 32'(err_count), 32'd2);
    check_output("malformed_level", 32'(level), 32'd0);
`endif
    repeat (2) apply_stimulus(1'b0, 12'h000, 1'b1);

    // Counter saturation
    repeat (260) apply_stimulus(1'b1, 12'h000, 1'b0);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("err_saturated", 32'(err_count), 32'hFF);

    // Asynchronous reset with entries queued
    apply_stimulus(1'b1, 12'h001, 1'b0);
    apply_stimulus(1'b1, 12'h020, 1'b0);
    apply_stimulus(1'b1, 12'h200, 1'b0);
    apply_stimulus(1'b0, 12'h000, 1'b0);
    check_output("prereset_level", 32'(level), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_op_valid", 32'(op_valid), 32'd0);
    check_output("async_level", 32'(level), 32'd0);
    check_output("async_sel_ready", 32'(sel_ready), 32'd1);
    check_output("async_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      s = 12'h000;
      else if (r == 1) s = 12'($urandom);
      else             s = 12'h001 << $urandom_range(0, 11);
      apply_stimulus($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
    end
    repeat (DEPTH + 2) apply_stimulus(1'b0, 12'h000, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
